// File: rtl/memory_game_pkg.sv
// Shared constants and types for the memory-game datapath: board geometry,
// shuffler state encoding and the LFSR feedback mask.
package memory_game_pkg;

   localparam int N_CARDS = 16;
   localparam int COLOR_W = 3;
   localparam int IDX_W   = 4;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      SHUFFLE = 2'd2,
      DONE    = 2'd3
   } shuffle_state_t;

endpackage

// File: rtl/card_shuffler_if.sv
// Controller <-> shuffler connection: request/done handshake, table read port
// and observation signals for the FSM state and LFSR.
interface card_shuffler_if;
   import memory_game_pkg::*;

   // Handshake: compute_colors_en is a level request held high by the
   // controller until it has seen compute_done, a single-cycle pulse issued
   // with the finished table already visible. The shuffler waits in DONE until
   // the request drops, so a lingering request never restarts a shuffle;
   // dropping the request before done aborts the run with no done pulse.
   logic                         compute_colors_en;
   logic                         compute_done;
   logic                         busy;
   logic [IDX_W-1:0]             rd_idx;
   logic [COLOR_W-1:0]           rd_color;
   logic [N_CARDS*COLOR_W-1:0]   card_colors;
   shuffle_state_t               dbg_state;
   logic [15:0]                  dbg_lfsr;

   modport master (
      output compute_colors_en, rd_idx,
      input  compute_done, busy, rd_color, card_colors, dbg_state, dbg_lfsr
   );

   modport slave (
      input  compute_colors_en, rd_idx,
      output compute_done, busy, rd_color, card_colors, dbg_state, dbg_lfsr
   );

endinterface

// File: rtl/card_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); steps every cycle
// after reset release and never reaches zero from a non-zero seed.
module lfsr16
   import memory_game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (state[0]) begin
         state <= (state >> 1) ^ LFSR_MASK;
      end else begin
         state <= state >> 1;
      end
   end

endmodule

// File: rtl/card_shuffler.sv
// Builds the 4x4 board colour table (8 pairs) and shuffles it in place with a
// Fisher-Yates pass driven by the free-running LFSR.
module card_shuffler
   import memory_game_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   card_shuffler_if.slave   bus
);

   logic [15:0]          lfsr;
   logic [COLOR_W-1:0]   table_q [N_CARDS];
   shuffle_state_t       state_q;
   logic [IDX_W-1:0]     idx;
   logic                 done_q;
   logic                 busy_q;
   logic [IDX_W:0]       span;
   logic [IDX_W+7:0]     prod;
   logic [IDX_W-1:0]     j;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   // j = (r * (i+1)) >> 8 lands in 0..i; the product is below 2^12, so the
   // top bit of the nominal 13-bit product is always zero and is not kept.
   assign span = {1'b0, idx} + (IDX_W+1)'(1);
   assign prod = {{IDX_W{1'b0}}, lfsr[7:0]} * {7'd0, span};
   assign j    = prod[IDX_W+7:8];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         for (int k = 0; k < N_CARDS; k++) table_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.compute_colors_en) begin
                  state_q <= FILL;
                  idx     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            FILL: begin
               if (!bus.compute_colors_en) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  table_q[idx] <= idx[IDX_W-1:1];
                  if (idx == IDX_W'(N_CARDS-1)) state_q <= SHUFFLE;
                  else                          idx     <= idx + IDX_W'(1);
               end
            end
            SHUFFLE: begin
               if (!bus.compute_colors_en) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  // When j == idx both writes carry the same value.
                  table_q[idx] <= table_q[j];
                  table_q[j]   <= table_q[idx];
                  if (idx == IDX_W'(1)) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx <= idx - IDX_W'(1);
                  end
               end
            end
            DONE: begin
               if (!bus.compute_colors_en) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.card_colors = '0;
      for (int k = 0; k < N_CARDS; k++) begin
         bus.card_colors[k*COLOR_W +: COLOR_W] = table_q[k];
      end
   end

   assign bus.rd_color     = table_q[bus.rd_idx];
   assign bus.compute_done = done_q;
   assign bus.busy         = busy_q;
   assign bus.dbg_state    = state_q;
   assign bus.dbg_lfsr     = lfsr;

endmodule

// File: tb/tb_card_shuffler.sv
// Directed request/abort/reset sequence with randomized start delays; each
// finished board is compared against a Fisher-Yates reference run on a model LFSR.
module tb_card_shuffler;
  import memory_game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  card_shuffler_if bus();

  card_shuffler #(.LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int unsigned ncyc;
  logic [COLOR_W-1:0] exp_q[$];
  logic [N_CARDS*COLOR_W-1:0] tbl1;
  logic [N_CARDS*COLOR_W-1:0] tbl2;
  int d1;

  // Edges seen since reset release; the LFSR value in the current cycle is lfsr_at(ncyc).
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int unsigned n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int unsigned k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Request sampled in the cycle where lfsr_at(n0) is current; swap for card i
  // happens 32-i cycles later.
  task automatic build_model(input int unsigned n0);
    int tbl[N_CARDS];
    int jj, t;
    logic [15:0] v;
    for (int k = 0; k < N_CARDS; k++) tbl[k] = k / 2;
    for (int i = N_CARDS - 1; i >= 1; i--) begin
      v = lfsr_at(n0 + 32 - i);
      jj = (int'(v[7:0]) * (i + 1)) / 256;
      t = tbl[i]; tbl[i] = tbl[jj]; tbl[jj] = t;
    end
    exp_q = {};
    for (int k = 0; k < N_CARDS; k++) exp_q.push_back(COLOR_W'(tbl[k]));
  endtask

  function automatic logic [N_CARDS*COLOR_W-1:0] model_flat();
    logic [N_CARDS*COLOR_W-1:0] f;
    f = '0;
    for (int k = 0; k < N_CARDS; k++) f[k*COLOR_W +: COLOR_W] = exp_q[k];
    return f;
  endfunction

  task automatic check_histogram(input string tag);
    int cnt[N_CARDS/2];
    logic [COLOR_W-1:0] c;
    for (int k = 0; k < N_CARDS/2; k++) cnt[k] = 0;
    for (int k = 0; k < N_CARDS; k++) begin
      c = bus.card_colors[k*COLOR_W +: COLOR_W];
      cnt[c]++;
    end
    for (int k = 0; k < N_CARDS/2; k++) check($sformatf("%s_hist%0d", tag, k), 64'(cnt[k]), 64'd2);
  endtask

  // Drive/sample on the falling edge. abort_at>0 drops the request in that cycle.
  task automatic do_request(input string tag, input int abort_at, input int hold);
    bus.compute_colors_en = 1'b1;
    build_model(ncyc);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (abort_at != 0 && k == abort_at + 1) begin
        check({tag, "_abort_state"}, 64'(bus.dbg_state), 64'(IDLE));
        check({tag, "_abort_busy"}, 64'(bus.busy), 64'd0);
        for (int h = 0; h < 15; h++) begin
          @(negedge clk);
          tests++;
          assert (bus.compute_done === 1'b0 && bus.dbg_state === IDLE) else begin
            fails++;
            $error("FAIL %s_abort_idle: done=%0b state=%0d want done=0 state=0", tag, bus.compute_done, bus.dbg_state);
          end
        end
        return;
      end
      check($sformatf("%s_busy_c%0d", tag, k), 64'(bus.busy), 64'(k <= 31));
      check($sformatf("%s_done_c%0d", tag, k), 64'(bus.compute_done), 64'(k == 32));
      if (abort_at != 0 && k == abort_at) bus.compute_colors_en = 1'b0;
    end
    check({tag, "_table"}, 64'(bus.card_colors), 64'(model_flat()));
    check({tag, "_state_done"}, 64'(bus.dbg_state), 64'(DONE));
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      tests++;
      assert (bus.compute_done === 1'b0 && bus.dbg_state === DONE && bus.card_colors === model_flat()) else begin
        fails++;
        $error("FAIL %s_hold%0d: done=%0b state=%0d table=%0h want done=0 state=3 table=%0h",
               tag, h, bus.compute_done, bus.dbg_state, bus.card_colors, model_flat());
      end
    end
    bus.compute_colors_en = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, 64'(bus.dbg_state), 64'(IDLE));
    check({tag, "_no_done"}, 64'(bus.compute_done), 64'd0);
  endtask

  task automatic release_and_wait(input int d);
    rst = 1'b1;
    #1;
    check("lfsr_seed", 64'(bus.dbg_lfsr), 64'hACE1);
    repeat (d) @(negedge clk);
  endtask

  initial begin
    bus.compute_colors_en = 1'b0;
    bus.rd_idx = '0;
    d1 = $urandom_range(3, 20);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_colors", 64'(bus.card_colors), 64'd0);
    check("rst_rd_color", 64'(bus.rd_color), 64'd0);
    check("rst_done", 64'(bus.compute_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    release_and_wait(d1);

    // Single shuffle, request dropped one cycle after done
    do_request("first", 0, 1);
    tbl1 = model_flat();
    check_histogram("first");

    // Table stays put while idle, then a second request held 50 cycles past done
    repeat (37) @(negedge clk);
    check("idle_stable", 64'(bus.card_colors), 64'(tbl1));
    do_request("second", 0, 50);
    tbl2 = model_flat();
    check_histogram("second");
    check("second_differs", 64'(bus.card_colors != tbl1), 64'd1);

    // Read port sweep against the reference table
    for (int k = 0; k < N_CARDS; k++) begin
      bus.rd_idx = IDX_W'(k);
      #1;
      check($sformatf("rd_color%0d", k), 64'(bus.rd_color), 64'(exp_q[k]));
    end
    @(negedge clk);

    // Abort in SHUFFLE, then a fresh complete request
    repeat ($urandom_range(1, 9)) @(negedge clk);
    do_request("abort", 20, 0);
    do_request("after_abort", 0, 1);
    check_histogram("after_abort");

    // Reset in the middle of FILL
    bus.compute_colors_en = 1'b1;
    repeat (10) @(negedge clk);
    check("midrun_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    bus.compute_colors_en = 1'b0;
    #1;
    check("midrun_colors", 64'(bus.card_colors), 64'd0);
    check("midrun_done", 64'(bus.compute_done), 64'd0);
    check("midrun_busy", 64'(bus.busy), 64'd0);
    check("midrun_state", 64'(bus.dbg_state), 64'(IDLE));
    @(negedge clk);

    // Same seed and same request timing reproduce the first board
    release_and_wait(d1);
    do_request("repeat", 0, 1);
    check("repeat_same", 64'(bus.card_colors), 64'(tbl1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
